// File: rtl/duty_ramp.sv
// Slew-limited duty request for the 11-bit PWM generator: soft start, ramp-down, brake cut-off.
// Optional build macro DUTY_CLAMP_EN caps the captured target at MAX_DUTY.
module duty_ramp #(
  parameter logic [10:0] STEP_UP  = 11'd8,
  parameter logic [10:0] STEP_DN  = 11'd32,
  parameter logic [10:0] MAX_DUTY = 11'h7C0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        brake,
  input  logic [10:0] target,
  input  logic        target_vld,
  output logic [10:0] duty,
  output logic        prd_strt,
  output logic        at_target
);

  typedef enum logic [1:0] {StIdle, StRamp, StHold, StBrake} state_e;

`ifdef DUTY_CLAMP_EN
  localparam bit ClampEn = 1'b1;
`else
  localparam bit ClampEn = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [10:0] per_cnt_q, per_cnt_d;
  logic [10:0] tgt_q, tgt_d;
  logic [10:0] duty_q, duty_d;
  logic        prd_strt_q, prd_strt_d;
  logic        at_target_q, at_target_d;

  logic        tick;
  logic [10:0] tgt_cap;
  logic [10:0] eff_tgt;
  logic [10:0] step_duty;
  logic [11:0] diff_up, diff_dn;

  assign tick      = (per_cnt_q == 11'h7FF);
  assign per_cnt_d = per_cnt_q + 11'd1;
  assign tgt_cap   = (ClampEn && (target > MAX_DUTY)) ? MAX_DUTY : target;
  assign tgt_d     = target_vld ? tgt_cap : tgt_q;

  // Drive disabled means ramp toward zero rather than cut off.
  assign eff_tgt = en ? tgt_q : 11'd0;
  assign diff_up = {1'b0, eff_tgt} - {1'b0, duty_q};
  assign diff_dn = {1'b0, duty_q} - {1'b0, eff_tgt};

  always_comb begin
    step_duty = eff_tgt;
    if (eff_tgt > duty_q) begin
      if (diff_up > {1'b0, STEP_UP}) step_duty = duty_q + STEP_UP;
    end else begin
      if (diff_dn > {1'b0, STEP_DN}) step_duty = duty_q - STEP_DN;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    if (brake) begin
      state_d = StBrake;
      duty_d  = 11'd0;
    end else begin
      case (state_q)
        StIdle: begin
          duty_d = 11'd0;
          if (en && (tgt_q != 11'd0)) state_d = StRamp;
        end
        StRamp: begin
          if (tick) begin
            duty_d = step_duty;
            if (step_duty == eff_tgt) state_d = en ? StHold : StIdle;
          end
        end
        StHold: begin
          if (eff_tgt != duty_q) state_d = StRamp;
          else if (!en)          state_d = StIdle;
        end
        StBrake: begin
          duty_d  = 11'd0;
          state_d = StIdle;
        end
        default: begin
          duty_d  = 11'd0;
          state_d = StIdle;
        end
      endcase
    end
    prd_strt_d  = tick;
    at_target_d = (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      per_cnt_q   <= 11'd0;
      tgt_q       <= 11'd0;
      duty_q      <= 11'd0;
      prd_strt_q  <= 1'b0;
      at_target_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      tgt_q       <= tgt_d;
      duty_q      <= duty_d;
      prd_strt_q  <= prd_strt_d;
      at_target_q <= at_target_d;
    end
  end

  assign duty      = duty_q;
  assign prd_strt  = prd_strt_q;
  assign at_target = at_target_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: three instances run directed scenarios in parallel against a
// behavioural model; instance 1 uses a large up-step to keep long ramps short.
module tb_duty_ramp;

  localparam int NInst = 3;
  localparam int MIdle = 0, MRamp = 1, MHold = 2, MBrake = 3;
`ifdef DUTY_CLAMP_EN
  localparam int FullDuty = 'h7C0;
`else
  localparam int FullDuty = 'h7FF;
`endif

  logic              clk;
  logic [NInst-1:0]  rst_n_s, en_s, brake_s, vld_s, prd_w, at_w;
  logic [10:0]       tgt_s  [NInst];
  logic [10:0]       duty_w [NInst];

  int n_cmp, n_bad;
  bit chk_on;

  // Behavioural model state
  int m_cnt [NInst], m_tgt [NInst], m_duty [NInst], m_st [NInst];
  bit m_prd [NInst];
  int m_up  [NInst] = '{8, 256, 8};
  int m_dn  [NInst] = '{32, 32, 32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  duty_ramp u0 (
    .clk(clk), .rst_n(rst_n_s[0]), .en(en_s[0]), .brake(brake_s[0]), .target(tgt_s[0]),
    .target_vld(vld_s[0]), .duty(duty_w[0]), .prd_strt(prd_w[0]), .at_target(at_w[0])
  );

  duty_ramp #(.STEP_UP(11'h100)) u1 (
    .clk(clk), .rst_n(rst_n_s[1]), .en(en_s[1]), .brake(brake_s[1]), .target(tgt_s[1]),
    .target_vld(vld_s[1]), .duty(duty_w[1]), .prd_strt(prd_w[1]), .at_target(at_w[1])
  );

  duty_ramp u2 (
    .clk(clk), .rst_n(rst_n_s[2]), .en(en_s[2]), .brake(brake_s[2]), .target(tgt_s[2]),
    .target_vld(vld_s[2]), .duty(duty_w[2]), .prd_strt(prd_w[2]), .at_target(at_w[2])
  );

  function automatic int approach(int cur, int goal, int up, int dn);
    if (goal > cur) return (cur + up < goal) ? cur + up : goal;
    return (cur - dn > goal) ? cur - dn : goal;
  endfunction

  function automatic int capture(int t);
`ifdef DUTY_CLAMP_EN
    return (t > 'h7C0) ? 'h7C0 : t;
`else
    return t;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model advances on every active edge from the spec's rules.
  initial begin
    int goal;
    bit tick;
    forever begin
      @(posedge clk);
      for (int i = 0; i < NInst; i++) begin
        if (!rst_n_s[i]) begin
          m_cnt[i] = 0; m_tgt[i] = 0; m_duty[i] = 0; m_prd[i] = 0; m_st[i] = MIdle;
        end else begin
          tick     = (m_cnt[i] == 2047);
          goal     = en_s[i] ? m_tgt[i] : 0;
          m_prd[i] = tick;
          m_cnt[i] = (m_cnt[i] + 1) % 2048;
          if (brake_s[i]) begin
            m_st[i]   = MBrake;
            m_duty[i] = 0;
          end else begin
            case (m_st[i])
              MIdle: if (en_s[i] && m_tgt[i] != 0) m_st[i] = MRamp;
              MRamp: if (tick) begin
                m_duty[i] = approach(m_duty[i], goal, m_up[i], m_dn[i]);
                if (m_duty[i] == goal) m_st[i] = en_s[i] ? MHold : MIdle;
              end
              MHold: begin
                if (goal != m_duty[i]) m_st[i] = MRamp;
                else if (!en_s[i])     m_st[i] = MIdle;
              end
              default: m_st[i] = MIdle;
            endcase
          end
          if (vld_s[i]) m_tgt[i] = capture(int'(tgt_s[i]));
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int i = 0; i < NInst; i++) begin
          chk($sformatf("u%0d.duty", i), 32'(duty_w[i]), 32'(m_duty[i]));
          chk($sformatf("u%0d.prd_strt", i), 32'(prd_w[i]), 32'(m_prd[i]));
          chk($sformatf("u%0d.at_target", i), 32'(at_w[i]), 32'(m_st[i] == MHold));
        end
      end
    end
  end

  // Soft start 0 -> 0x100 at 8 per period.
  task automatic run0();
    rst_n_s[0] = 1'b1; en_s[0] = 1'b1; tgt_s[0] = 11'h100; vld_s[0] = 1'b1;
    cyc(1);       vld_s[0] = 1'b0;
    cyc(2046);    chk("t1 duty before first tick", 32'(duty_w[0]), 32'h000);
                  chk("t1 prd_strt before tick", 32'(prd_w[0]), 32'h0);
    cyc(1);       chk("t1 duty first step", 32'(duty_w[0]), 32'h008);
                  chk("t1 prd_strt first period", 32'(prd_w[0]), 32'h1);
    cyc(1);       chk("t1 prd_strt one cycle", 32'(prd_w[0]), 32'h0);
    cyc(2047);    chk("t1 duty second step", 32'(duty_w[0]), 32'h010);
    cyc(2048*29); chk("t1 duty period 31", 32'(duty_w[0]), 32'h0F8);
                  chk("t1 at_target still ramping", 32'(at_w[0]), 32'h0);
    cyc(2048);    chk("t1 duty reaches target", 32'(duty_w[0]), 32'h100);
                  chk("t1 at_target in hold", 32'(at_w[0]), 32'h1);
  endtask

  // Ramp-down limit, en=0 ramp-down, full-scale / clamped ramp-up.
  task automatic run1();
    rst_n_s[1] = 1'b1; en_s[1] = 1'b1; tgt_s[1] = 11'h100; vld_s[1] = 1'b1;
    cyc(1);       vld_s[1] = 1'b0;
    cyc(2047);    chk("t2 start duty", 32'(duty_w[1]), 32'h100);
                  chk("t2 start hold", 32'(at_w[1]), 32'h1);
    tgt_s[1] = 11'h010; vld_s[1] = 1'b1;
    cyc(1);       vld_s[1] = 1'b0;
    cyc(1);       chk("t2 leave hold", 32'(at_w[1]), 32'h0);
                  chk("t2 duty held until tick", 32'(duty_w[1]), 32'h100);
    cyc(2046);    chk("t2 first down step", 32'(duty_w[1]), 32'h0E0);
    cyc(2048);    chk("t2 second down step", 32'(duty_w[1]), 32'h0C0);
    cyc(2048*6);  chk("t2 lands on target", 32'(duty_w[1]), 32'h010);
                  chk("t2 hold after landing", 32'(at_w[1]), 32'h1);
    tgt_s[1] = 11'h050; vld_s[1] = 1'b1;
    cyc(1);       vld_s[1] = 1'b0;
    cyc(2047);    chk("t4 start duty", 32'(duty_w[1]), 32'h050);
    en_s[1] = 1'b0;
    cyc(2048);    chk("t4 en=0 step 1", 32'(duty_w[1]), 32'h030);
                  chk("t4 not at target", 32'(at_w[1]), 32'h0);
    cyc(1000);    chk("t4 no change between ticks", 32'(duty_w[1]), 32'h030);
    cyc(1048);    chk("t4 en=0 step 2", 32'(duty_w[1]), 32'h010);
    cyc(2048);    chk("t4 en=0 reaches zero", 32'(duty_w[1]), 32'h000);
    en_s[1] = 1'b1; tgt_s[1] = 11'h7FF; vld_s[1] = 1'b1;
    cyc(1);       vld_s[1] = 1'b0;
    cyc(2047);    chk("t6 first up step", 32'(duty_w[1]), 32'h100);
    cyc(2048*7);  chk("t6 final duty", 32'(duty_w[1]), 32'(FullDuty));
                  chk("t6 at_target", 32'(at_w[1]), 32'h1);
  endtask

  // Brake mid-ramp, strobe on tick edge, reset mid-ramp.
  task automatic run2();
    rst_n_s[2] = 1'b1; en_s[2] = 1'b1; tgt_s[2] = 11'h100; vld_s[2] = 1'b1;
    cyc(1);       vld_s[2] = 1'b0;
    cyc(4095);    chk("t3 pre-brake duty", 32'(duty_w[2]), 32'h010);
    cyc(100);     brake_s[2] = 1'b1;
    cyc(1);       chk("t3 brake cuts duty", 32'(duty_w[2]), 32'h000);
                  chk("t3 brake at_target", 32'(at_w[2]), 32'h0);
                  brake_s[2] = 1'b0;
    cyc(1946);    chk("t3 zero until tick", 32'(duty_w[2]), 32'h000);
    cyc(1);       chk("t3 soft restart", 32'(duty_w[2]), 32'h008);
    cyc(2047);    tgt_s[2] = 11'h00C; vld_s[2] = 1'b1;
    cyc(1);       vld_s[2] = 1'b0;
                  chk("t5 step uses old target", 32'(duty_w[2]), 32'h010);
    cyc(2048);    chk("t5 new target next tick", 32'(duty_w[2]), 32'h00C);
                  chk("t5 hold", 32'(at_w[2]), 32'h1);
    tgt_s[2] = 11'h100; vld_s[2] = 1'b1;
    cyc(1);       vld_s[2] = 1'b0;
    cyc(2047);    chk("rst pre-reset duty", 32'(duty_w[2]), 32'h014);
    cyc(10);      rst_n_s[2] = 1'b0;
    cyc(1);       chk("rst duty cleared", 32'(duty_w[2]), 32'h000);
                  chk("rst prd_strt cleared", 32'(prd_w[2]), 32'h0);
                  rst_n_s[2] = 1'b1;
    cyc(2048);    chk("rst stays idle", 32'(duty_w[2]), 32'h000);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_on = 1'b0;
    rst_n_s = '0; en_s = '0; brake_s = '0; vld_s = '0;
    for (int i = 0; i < NInst; i++) tgt_s[i] = 11'h000;
    cyc(3);
    for (int i = 0; i < NInst; i++) begin
      chk($sformatf("reset u%0d.duty", i), 32'(duty_w[i]), 32'h0);
      chk($sformatf("reset u%0d.prd_strt", i), 32'(prd_w[i]), 32'h0);
      chk($sformatf("reset u%0d.at_target", i), 32'(at_w[i]), 32'h0);
    end
    chk_on = 1'b1;
    fork
      run0();
      run1();
      run2();
    join
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
